// File: rtl/intr_ctrl.sv
// Interrupt controller feeding mips_core's single interrupter input: per-source sync,
// rising-edge pend, mask, fixed lowest-index-first priority, and ack/EOI service handshake.
module intr_ctrl #(
    parameter int               N_SRC       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_SRC-1:0] MASK_RST    = {N_SRC{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             intr_ack,
    input  logic             bus_ren,
    input  logic             bus_wen,
    input  logic [4:0]       bus_addr,
    input  logic [31:0]      bus_din,
    output logic [31:0]      bus_dout,
    output logic             intr_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_MASK   = 3'd1;
    localparam logic [2:0] REG_CLEAR  = 3'd2;
    localparam logic [2:0] REG_CAUSE  = 3'd3;
    localparam logic [2:0] REG_EOI    = 3'd4;

    // Lowest-index set bit wins; scanning downward lets the lowest index overwrite last.
    function automatic logic [7:0] first_set(input logic [N_SRC-1:0] vec);
        logic [7:0] id;
        id = 8'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = 8'(i);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    logic [N_SRC-1:0] sync_r [SYNC_STAGES];
    logic [N_SRC-1:0] prev_r;
    logic [N_SRC-1:0] pending_r;
    logic [N_SRC-1:0] mask_r;
    logic             cause_valid_r;
    logic [7:0]       cause_id_r;
    state_t           state_r;
    logic             intr_out_r;
    logic             busy_r;

    logic [N_SRC-1:0] sync_last_s;
    logic [N_SRC-1:0] rise_s;
    logic [N_SRC-1:0] clr_wr_s;
    logic [N_SRC-1:0] ack_clr_s;
    logic [N_SRC-1:0] pending_d_s;
    logic [N_SRC-1:0] mask_d_s;
    logic             wr_mask_s;
    logic             wr_clr_s;
    logic             wr_eoi_s;
    logic             req_s;
    logic             req_next_s;
    logic             ack_take_s;
    logic             eoi_take_s;
    logic [7:0]       id_s;
    state_t           state_s;
    logic [31:0]      rd_data_s;
    logic             unused_s;

    assign unused_s = ^{bus_addr[1:0], bus_din};

    assign wr_mask_s   = bus_wen && (bus_addr[4:2] == REG_MASK);
    assign wr_clr_s    = bus_wen && (bus_addr[4:2] == REG_CLEAR);
    assign wr_eoi_s    = bus_wen && (bus_addr[4:2] == REG_EOI);
    assign sync_last_s = sync_r[SYNC_STAGES-1];
    assign rise_s      = sync_last_s & ~prev_r;
    assign req_s       = |(pending_r & mask_r);
    assign id_s        = first_set(pending_r & mask_r);
    assign ack_take_s  = (state_r == ST_REQ) && intr_ack && req_s;
    assign eoi_take_s  = (state_r == ST_SERVICE) && wr_eoi_s;

    // Next pending/mask values: new edges win over CLEAR and ack clears of the same bit.
    always_comb begin
        clr_wr_s  = {N_SRC{1'b0}};
        ack_clr_s = {N_SRC{1'b0}};
        if (wr_clr_s) begin
            clr_wr_s = bus_din[N_SRC-1:0];
        end else begin
            clr_wr_s = {N_SRC{1'b0}};
        end
        for (int i = 0; i < N_SRC; i++) begin
            ack_clr_s[i] = ack_take_s && (id_s == 8'(i));
        end
        pending_d_s = (pending_r & ~(clr_wr_s | ack_clr_s)) | rise_s;
        mask_d_s    = wr_mask_s ? bus_din[N_SRC-1:0] : mask_r;
        req_next_s  = |(pending_d_s & mask_d_s);
    end

    // Service FSM next state; a request dropped by CLEAR/MASK leaves REQ without waiting a cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) state_s = ST_REQ;
                else       state_s = ST_IDLE;
            end
            ST_REQ: begin
                if (ack_take_s)       state_s = ST_SERVICE;
                else if (!req_next_s) state_s = ST_IDLE;
                else                  state_s = ST_REQ;
            end
            ST_SERVICE: begin
                if (eoi_take_s) state_s = ST_IDLE;
                else            state_s = ST_SERVICE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Register read mux; unmapped and write-only addresses read zero.
    always_comb begin
        rd_data_s = 32'd0;
        if (bus_ren) begin
            case (bus_addr[4:2])
                REG_STATUS: rd_data_s = 32'(pending_r);
                REG_MASK:   rd_data_s = 32'(mask_r);
                REG_CAUSE:  rd_data_s = {cause_valid_r, 23'd0, cause_id_r};
                default:    rd_data_s = 32'd0;
            endcase
        end else begin
            rd_data_s = 32'd0;
        end
    end

    // Source synchronisers and edge-history flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= {N_SRC{1'b0}};
            prev_r <= {N_SRC{1'b0}};
        end else begin
            sync_r[0] <= irq_src;
            for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
            prev_r <= sync_last_s;
        end
    end

    // Pending/mask/cause state, FSM register and registered core-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r     <= {N_SRC{1'b0}};
            mask_r        <= MASK_RST;
            cause_valid_r <= 1'b0;
            cause_id_r    <= 8'd0;
            state_r       <= ST_IDLE;
            intr_out_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            pending_r  <= pending_d_s;
            mask_r     <= mask_d_s;
            state_r    <= state_s;
            intr_out_r <= (state_s == ST_REQ);
            busy_r     <= (state_s == ST_SERVICE);
            if (ack_take_s) begin
                cause_valid_r <= 1'b1;
                cause_id_r    <= id_s;
            end else if (eoi_take_s) begin
                cause_valid_r <= 1'b0;
            end
        end
    end

    assign bus_dout = rd_data_s;
    assign intr_out = intr_out_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: each vector is one clock cycle of inputs plus the
// outputs expected during that cycle (before its closing edge).
module tb_intr_ctrl;

    localparam logic [4:0] A_STATUS = 5'h00;
    localparam logic [4:0] A_MASK   = 5'h04;
    localparam logic [4:0] A_CLEAR  = 5'h08;
    localparam logic [4:0] A_CAUSE  = 5'h0C;
    localparam logic [4:0] A_EOI    = 5'h10;

    typedef struct {
        logic        chk;
        logic        rst;
        logic [3:0]  irq;
        logic        ack;
        logic        ren;
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] dout;
        logic        intr;
        logic        busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_src;
    logic        intr_ack;
    logic        bus_ren;
    logic        bus_wen;
    logic [4:0]  bus_addr;
    logic [31:0] bus_din;
    logic [31:0] bus_dout;
    logic        intr_out;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int row_no  = 0;
    vec_t tbl[$];

    intr_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .intr_ack (intr_ack),
        .bus_ren  (bus_ren),
        .bus_wen  (bus_wen),
        .bus_addr (bus_addr),
        .bus_din  (bus_din),
        .bus_dout (bus_dout),
        .intr_out (intr_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst_v, input logic [3:0] irq_v, input logic ack_v,
                                input logic ren_v, input logic wen_v, input logic [4:0] addr_v,
                                input logic [31:0] din_v, input logic [31:0] dout_v,
                                input logic intr_v, input logic busy_v);
        vec_t v;
        v.chk = 1'b1; v.rst = rst_v; v.irq = irq_v; v.ack = ack_v; v.ren = ren_v;
        v.wen = wen_v; v.addr = addr_v; v.din = din_v; v.dout = dout_v;
        v.intr = intr_v; v.busy = busy_v;
        return v;
    endfunction

    task automatic step(input vec_t v);
        rst = v.rst; irq_src = v.irq; intr_ack = v.ack; bus_ren = v.ren;
        bus_wen = v.wen; bus_addr = v.addr; bus_din = v.din;
        #1;
        if (v.chk) begin
            n_tests++;
            if (bus_dout !== v.dout) begin
                n_fail++;
                $display("FAIL row %0d bus_dout: got %h expected %h", row_no, bus_dout, v.dout);
            end
            n_tests++;
            if (intr_out !== v.intr) begin
                n_fail++;
                $display("FAIL row %0d intr_out: got %b expected %b", row_no, intr_out, v.intr);
            end
            n_tests++;
            if (busy !== v.busy) begin
                n_fail++;
                $display("FAIL row %0d busy: got %b expected %b", row_no, busy, v.busy);
            end
        end
        row_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // Reset, single pulse on source 2, ack then EOI.
        v = mk(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, A_STATUS, 32'd0, 32'd0, 1'b0, 1'b0);
        v.chk = 1'b0;
        tbl.push_back(v);
        tbl.push_back(mk(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, A_MASK,   32'd0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, A_MASK,   32'h4, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h4, 1'b0, 1'b1, 1'b0, A_MASK,   32'd0, 32'h4, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h4, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, A_CAUSE,  32'd0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, A_CAUSE,  32'd0, 32'h80000002, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, A_EOI,    32'd0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, A_CAUSE,  32'd0, 32'h00000002, 1'b0, 1'b0));
        // Sources 3 and 1 together: lower index served first, then 3 after EOI.
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, A_MASK,   32'hF, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'hA, 1'b0, 1'b1, 1'b0, A_MASK,   32'd0, 32'hF, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'hA, 1'b0, 1'b0, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'hA, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'hA, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'hA, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'hA, 1'b1, 1'b1, 1'b0, A_STATUS, 32'd0, 32'hA, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, A_CAUSE,  32'd0, 32'h80000001, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h8, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, A_EOI,    32'd0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h8, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, A_CAUSE,  32'd0, 32'h80000003, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, A_EOI,    32'd0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, A_CAUSE,  32'd0, 32'h00000003, 1'b0, 1'b0));
        // Masked source 0 stays pending; unmask raises request two edges later.
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, A_MASK,   32'h0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 1'b1, 1'b0, A_MASK,   32'd0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 1'b0, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 1'b0, 1'b1, A_MASK,   32'h1, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 1'b1, 1'b0, A_MASK,   32'd0, 32'h1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 1'b1, 1'b0, A_MASK,   32'd0, 32'h1, 1'b1, 1'b0));
        // CLEAR while in REQ withdraws the request; a late ack is ignored.
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 1'b0, 1'b1, A_CLEAR,  32'h1, 32'h0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b1, 1'b1, 1'b0, A_CAUSE,  32'd0, 32'h00000003, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h1, 1'b0, 1'b1, 1'b0, A_CAUSE,  32'd0, 32'h00000003, 1'b0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Edge of source 2 coincides with CLEAR of bit 2: set wins.
        step(mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, A_MASK,   32'hF, 32'h0, 1'b0, 1'b0));
        step(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        step(mk(1'b0, 4'h6, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        step(mk(1'b0, 4'h6, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        step(mk(1'b0, 4'h6, 1'b0, 1'b0, 1'b1, A_CLEAR,  32'h4, 32'h0, 1'b0, 1'b0));
        step(mk(1'b0, 4'h6, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h6, 1'b0, 1'b0));
        // Ack coincides with CLEAR of the winning bit: cause uses pre-write pending.
        step(mk(1'b0, 4'h6, 1'b1, 1'b0, 1'b1, A_CLEAR,  32'h2, 32'h0, 1'b1, 1'b0));
        step(mk(1'b0, 4'h6, 1'b0, 1'b1, 1'b0, A_CAUSE,  32'd0, 32'h80000001, 1'b0, 1'b1));
        step(mk(1'b0, 4'h6, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h4, 1'b0, 1'b1));

        // Reset while busy with source 1 held high; it re-pends exactly once afterwards.
        step(mk(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b1));
        step(mk(1'b1, 4'h2, 1'b0, 1'b1, 1'b0, A_MASK,   32'd0, 32'h0, 1'b0, 1'b0));
        step(mk(1'b1, 4'h2, 1'b0, 1'b1, 1'b0, A_CAUSE,  32'd0, 32'h0, 1'b0, 1'b0));
        step(mk(1'b1, 4'h2, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        step(mk(1'b0, 4'h2, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        step(mk(1'b0, 4'h2, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        step(mk(1'b0, 4'h2, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        step(mk(1'b0, 4'h2, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h2, 1'b0, 1'b0));
        step(mk(1'b0, 4'h2, 1'b0, 1'b0, 1'b1, A_CLEAR,  32'h2, 32'h0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            step(mk(1'b0, 4'h2, 1'b0, 1'b1, 1'b0, A_STATUS, 32'd0, 32'h0, 1'b0, 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
